// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked multi-cycle ALU with iterative shift-add multiply and restoring divide
module alu_seq #(
   parameter int N  = 32,
   parameter int CW = $clog2(N) + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   select,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic [1:0]   flags,
   output logic         div_zero
);

   localparam logic [3:0] OP_MOV = 4'd0;
   localparam logic [3:0] OP_CMP = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_MUL = 4'd4;
   localparam logic [3:0] OP_DIV = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_AND = 4'd7;
   localparam logic [3:0] OP_NOT = 4'd8;
   localparam logic [3:0] OP_MOD = 4'd9;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state;
   logic [3:0]    op;
   logic [N-1:0]  opa;   // multiplicand (shifts left) or dividend/quotient
   logic [N-1:0]  opb;   // multiplier (shifts right) or divisor
   logic [N-1:0]  acc;   // partial product or partial remainder
   logic [CW-1:0] cnt;

   logic [N-1:0]  diff;
   logic [N-1:0]  quick_res;
   logic [1:0]    quick_flags;
   logic          start_multi;

   always_comb begin
      diff      = a - b;
      quick_res = '0;
      case (select)
         OP_MOV:  quick_res = a;
         OP_ADD:  quick_res = a + b;
         OP_SUB:  quick_res = diff;
         OP_XOR:  quick_res = a ^ b;
         OP_AND:  quick_res = a & b;
         OP_NOT:  quick_res = ~a;
         default: quick_res = '0;
      endcase
      quick_flags = {quick_res[N-1], quick_res == '0};
      if (select == OP_CMP) begin
         quick_flags = {diff[N-1], diff == '0};
      end
      start_multi = (select == OP_MUL) || (select == OP_DIV) || (select == OP_MOD);
   end

   logic [N-1:0] mul_acc;
   logic [N:0]   rem_shift;
   logic         rem_ge;
   logic [N-1:0] rem_nxt;
   logic [N-1:0] quo_nxt;
   logic [N-1:0] fin_res;

   // A zero divisor always "fits", yielding all-ones quotient and remainder = a.
   always_comb begin
      mul_acc   = opb[0] ? acc + opa : acc;
      rem_shift = {acc, opa[N-1]};
      rem_ge    = rem_shift >= {1'b0, opb};
      rem_nxt   = rem_ge ? N'(rem_shift - {1'b0, opb}) : rem_shift[N-1:0];
      quo_nxt   = {opa[N-2:0], rem_ge};
      case (op)
         OP_MUL:  fin_res = mul_acc;
         OP_DIV:  fin_res = quo_nxt;
         default: fin_res = rem_nxt;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
         div_zero  <= 1'b0;
         cnt       <= '0;
         op        <= '0;
         opa       <= '0;
         opb       <= '0;
         acc       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op       <= select;
                  opa      <= a;
                  opb      <= b;
                  acc      <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  if (start_multi) begin
                     state <= BUSY;
                  end else begin
                     result    <= quick_res;
                     flags     <= quick_flags;
                     div_zero  <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            BUSY: begin
               cnt <= cnt + 1'b1;
               if (op == OP_MUL) begin
                  acc <= mul_acc;
                  opa <= opa << 1;
                  opb <= opb >> 1;
               end else begin
                  acc <= rem_nxt;
                  opa <= quo_nxt;
               end
               if (cnt == CW'(N - 1)) begin
                  result    <= fin_res;
                  flags     <= {fin_res[N-1], fin_res == '0};
                  div_zero  <= (op != OP_MUL) && (opb == '0);
                  out_valid <= 1'b1;
                  cnt       <= '0;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
